// File: rtl/xdma_c2h_dsc_arbiter.sv
// ============================================================================
// xdma_c2h_dsc_arbiter : two-port round-robin C2H descriptor-bypass arbiter
// Optional statistics counters enabled by macro XDMA_DSC_ARB_STATS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module xdma_c2h_dsc_arbiter #(
    parameter logic [15:0] DSC_CTL = 16'h0013,
    parameter int          LEN_W   = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [103:0]  S0_AXIS_tdata,
    input  logic          S0_AXIS_tvalid,
    output logic          S0_AXIS_tready,
    input  logic [103:0]  S1_AXIS_tdata,
    input  logic          S1_AXIS_tvalid,
    output logic          S1_AXIS_tready,
    input  logic          dsc_ready,
    output logic          dsc_load,
    output logic [15:0]   dsc_ctl,
    output logic [63:0]   dsc_src_addr,
    output logic [63:0]   dsc_dst_addr,
    output logic [27:0]   dsc_len,
    output logic [31:0]   grant_cnt0,
    output logic [31:0]   grant_cnt1,
    output logic [31:0]   drop_cnt
);

    localparam int C_DSC_LEN_W = 28;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_run;
    logic             r_last;
    logic             r_src;
    logic [63:0]      r_dst;
    logic [27:0]      r_len;

    logic             w_sel;
    logic             w_rdy;
    logic             w_hs;
    logic             w_len_zero;
    logic             w_load_done;
    logic [103:0]     w_tdata;
    logic             w_tvalid;
    logic             w_unused;

    // Upper tdata bits carry no meaning for this block.
    assign w_unused = ^{S0_AXIS_tdata, S1_AXIS_tdata};

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = ~r_last;
        if (S0_AXIS_tvalid && !S1_AXIS_tvalid) begin
            w_sel = 1'b0;
        end else if (S1_AXIS_tvalid && !S0_AXIS_tvalid) begin
            w_sel = 1'b1;
        end
        w_tdata     = w_sel ? S1_AXIS_tdata  : S0_AXIS_tdata;
        w_tvalid    = w_sel ? S1_AXIS_tvalid : S0_AXIS_tvalid;
        // r_run keeps tready low until the first clock edge after reset release.
        w_rdy       = r_run && (r_state == ST_IDLE);
        w_hs        = w_rdy && w_tvalid;
        w_len_zero  = (w_tdata[LEN_W-1:0] == '0);
        w_load_done = (r_state == ST_LOAD) && dsc_ready;
        case (r_state)
            ST_IDLE: if (w_hs && !w_len_zero) w_state_nxt = ST_LOAD;
            ST_LOAD: if (dsc_ready)           w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dst  <= '0;
            r_len  <= '0;
            r_src  <= 1'b0;
            r_last <= 1'b1;
        end else if (w_hs) begin
            if (w_len_zero) begin
                r_last <= w_sel;
            end else begin
                r_dst <= w_tdata[95:32];
                r_len <= C_DSC_LEN_W'(w_tdata[LEN_W-1:0]);
                r_src <= w_sel;
            end
        end else if (w_load_done) begin
            r_last <= r_src;
        end
    end

`ifdef XDMA_DSC_ARB_STATS_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_drop_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_load_done && !r_src) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            if (w_load_done &&  r_src) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            if (w_hs && w_len_zero)    r_drop_cnt   <= r_drop_cnt + 32'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign drop_cnt   = r_drop_cnt;
`else
    assign grant_cnt0 = 32'd0;
    assign grant_cnt1 = 32'd0;
    assign drop_cnt   = 32'd0;
`endif

    assign S0_AXIS_tready = w_rdy && !w_sel;
    assign S1_AXIS_tready = w_rdy &&  w_sel;
    assign dsc_load       = (r_state == ST_LOAD);
    assign dsc_ctl        = DSC_CTL;
    assign dsc_src_addr   = 64'd0;
    assign dsc_dst_addr   = r_dst;
    assign dsc_len        = r_len;

endmodule

`default_nettype wire

// File: doc/xdma_c2h_dsc_arbiter.md
XDMA_C2H_DSC_ARBITER -- requirements
Module: xdma_c2h_dsc_arbiter

Interface
REQ-001 The block SHALL have parameter DSC_CTL, default 16'h0013, meaning the control word driven on dsc_ctl for every loaded descriptor.
REQ-002 The block SHALL have parameter LEN_W, default 23, meaning the number of low tdata bits taken as transfer length.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have ports S0_AXIS_tdata and S1_AXIS_tdata, input, 104 each, descriptor words: [95:32] destination address, [LEN_W-1:0] length.
REQ-006 The block SHALL have ports S0_AXIS_tvalid/S1_AXIS_tvalid (input, 1) and S0_AXIS_tready/S1_AXIS_tready (output, 1), AXIS handshake per requester, no tlast/tkeep.
REQ-007 The block SHALL have port dsc_ready, input, 1, XDMA descriptor-bypass ready.
REQ-008 The block SHALL have outputs dsc_load (1), dsc_ctl (16), dsc_src_addr (64), dsc_dst_addr (64), dsc_len (28), the XDMA C2H descriptor-bypass interface.
REQ-009 The block SHALL have outputs grant_cnt0 and grant_cnt1 (32 each, loaded-descriptor counts) and drop_cnt (32, zero-length descriptors discarded).

Function
REQ-010 FSM SHALL have two states: IDLE (accepting) and LOAD (presenting descriptor).
REQ-011 In IDLE, exactly one tready SHALL be high: port 0 if only S0 valid, port 1 if only S1 valid; if both or neither valid, the port not granted last.
REQ-012 Both treadys SHALL be low in LOAD and while reset is high.
REQ-013 On an IDLE handshake with nonzero length, the block SHALL register dst_addr=tdata[95:32], len zero-extended to 28 bits, and the source port, then enter LOAD next cycle.
REQ-014 On an IDLE handshake with length zero, the block SHALL discard the word, increment drop_cnt, update the last-granted pointer, and remain in IDLE.
REQ-015 dsc_load SHALL equal (state==LOAD); dsc_ctl SHALL equal DSC_CTL; dsc_src_addr SHALL be constant 0.
REQ-016 In LOAD with dsc_ready high, the block SHALL return to IDLE next cycle, set last-granted to the loaded port, and increment that port's grant counter.
REQ-017 In LOAD with dsc_ready low, dsc_dst_addr/dsc_len/dsc_load SHALL hold stable indefinitely.
REQ-018 Minimum spacing SHALL be 2 cycles per loaded descriptor (accept cycle + load cycle); under continuous dual-port load, grants SHALL strictly alternate.
REQ-019 All counters SHALL wrap from 32'hFFFFFFFF to 0 without saturating.

Reset
REQ-020 On reset assertion (any cycle, including mid-LOAD) the block SHALL immediately enter IDLE, drive dsc_load=0, both tready=0, dsc_dst_addr=0, dsc_len=0, last-granted=port 1 (so port 0 wins first tie), all counters 0; an in-flight descriptor SHALL be abandoned.
REQ-021 After reset deassertion, tready SHALL assert no earlier than the first rising clk edge with reset low.

Configuration
REQ-022 With macro XDMA_DSC_ARB_STATS_EN defined, grant_cnt0, grant_cnt1 and drop_cnt SHALL operate per REQ-014/016/019.
REQ-023 Without XDMA_DSC_ARB_STATS_EN, those outputs SHALL be constant 0 and no counter registers SHALL be synthesized; arbitration behaviour SHALL be unchanged.

Verification
REQ-024 Single request: S0 valid, addr 64'h1000_0000, len 4096, dsc_ready high -> dsc_load high one cycle, dsc_dst_addr 64'h1000_0000, dsc_len 4096, dsc_ctl 16'h0013, grant_cnt0=1.
REQ-025 Contention: S0 and S1 continuously valid, 8 descriptors total, dsc_ready high -> order 0,1,0,1,...; grant_cnt0=4, grant_cnt1=4; one load every 2 cycles.
REQ-026 Backpressure: dsc_ready low 20 cycles during LOAD -> outputs stable, both tready low; release -> single load, no duplicate.
REQ-027 Zero length: S1 sends len 0 then len 64 -> drop_cnt=1, one load with dsc_len 64, grant_cnt1=1.
REQ-028 Reset mid-LOAD: assert reset while dsc_load high -> dsc_load low same cycle (async), counters 0; after release, S0 wins first tie.
